// File: rtl/game_controller.sv
// game_controller: Pong sequencer owning game state, key debounce, scoring and serve/point timing.
module game_controller #(
  parameter int WIN_SCORE       = 7,
  parameter int SERVE_FRAMES    = 60,
  parameter int POINT_FRAMES    = 90,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic       CLOCK_25,
  input  logic       RESET_N,
  input  logic       key0,
  input  logic       key1,
  input  logic       frame_tick,
  input  logic       miss_p1,
  input  logic       miss_p2,
  output logic       run,
  output logic       ball_reset,
  output logic       serve_left,
  output logic [2:0] score_1,
  output logic [2:0] score_2,
  output logic [1:0] winner,
  output logic [2:0] state,
  output logic [7:0] led
);
  localparam int SF = (SERVE_FRAMES == 0) ? 1 : SERVE_FRAMES;
  localparam int PF = (POINT_FRAMES == 0) ? 1 : POINT_FRAMES;
  localparam int MF = (SF > PF) ? SF : PF;
  localparam int FW = ($clog2(MF + 1) > 8) ? $clog2(MF + 1) : 8;
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [2:0] W = 3'(WIN_SCORE);

  typedef enum logic [2:0] {IDLE = 3'd0, SERVE, PLAY, PAUSED, POINT, OVER} state_t;

  logic [1:0] w_key, w_ev;
  assign w_key = {key1, key0};

  // Sync flops reset low so a key held through reset never arms until it is seen released.
  for (genvar k = 0; k < 2; k++) begin : g_key
    logic [1:0]    r_sync;
    logic          r_db, r_db_d, r_arm, r_ev;
    logic [CW-1:0] r_cnt;
    always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
      if (!RESET_N) begin
        r_sync <= 2'b00;
        r_db   <= 1'b1;
        r_db_d <= 1'b1;
        r_arm  <= 1'b0;
        r_ev   <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_sync <= {r_sync[0], w_key[k]};
        r_db_d <= r_db;
        r_arm  <= r_arm | r_sync[1];
        r_ev   <= r_arm & r_db_d & ~r_db;
        if (r_sync[1] == r_db) r_cnt <= '0;
        else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          r_db  <= r_sync[1];
          r_cnt <= '0;
        end else r_cnt <= r_cnt + 1'b1;
      end
    end
    assign w_ev[k] = r_ev;
  end

  logic          w_pause, w_cont;
  assign w_pause = w_ev[0];
  assign w_cont  = w_ev[1];

  state_t        r_state, w_state, r_resume, w_resume;
  logic [FW-1:0] r_frm, w_frm, w_inc;
  logic [2:0]    r_s1, r_s2, w_s1, w_s2, w_s1n, w_s2n;
  logic [1:0]    r_win, w_win;
  logic          r_sl, w_sl, r_br, w_br, r_run;
  logic [7:0]    r_led;

  always_comb begin
    w_state  = r_state;
    w_resume = r_resume;
    w_frm    = r_frm;
    w_s1     = r_s1;
    w_s2     = r_s2;
    w_win    = r_win;
    w_sl     = r_sl;
    w_br     = 1'b0;
    w_inc    = r_frm + FW'(1);
    w_s1n    = (r_s1 == W) ? r_s1 : r_s1 + {2'b00, miss_p2};
    w_s2n    = (r_s2 == W) ? r_s2 : r_s2 + {2'b00, miss_p1};
    case (r_state)
      IDLE: if (w_cont) begin
        w_state = SERVE;
        w_frm   = '0;
        w_br    = 1'b1;
      end
      SERVE: if (w_pause) begin
        w_state  = PAUSED;
        w_resume = SERVE;
      end else if (frame_tick) begin
        w_frm = w_inc;
        if (w_inc >= FW'(SF)) w_state = PLAY;
      end
      PLAY: if (miss_p1 | miss_p2) begin
        w_s1 = w_s1n;
        w_s2 = w_s2n;
        w_sl = (miss_p1 & ~miss_p2) ? 1'b1 : (miss_p2 & ~miss_p1) ? 1'b0 : r_sl;
        if (w_s1n == W || w_s2n == W) begin
          w_state = OVER;
          w_win   = {w_s2n == W, w_s1n == W};
          w_br    = 1'b1;
        end else begin
          w_state = POINT;
          w_frm   = '0;
        end
      end else if (w_pause) begin
        w_state  = PAUSED;
        w_resume = PLAY;
      end
      PAUSED: if (w_cont) w_state = w_resume;
      POINT: if (frame_tick) begin
        w_frm = w_inc;
        if (w_inc >= FW'(PF)) begin
          w_state = SERVE;
          w_frm   = '0;
          w_br    = 1'b1;
        end
      end
      OVER: if (w_cont) begin
        w_state = IDLE;
        w_s1    = '0;
        w_s2    = '0;
        w_win   = '0;
        w_sl    = 1'b0;
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state  <= IDLE;
      r_resume <= SERVE;
      r_frm    <= '0;
      r_s1     <= '0;
      r_s2     <= '0;
      r_win    <= '0;
      r_sl     <= 1'b0;
      r_br     <= 1'b0;
      r_run    <= 1'b0;
      r_led    <= 8'h01;
    end else begin
      r_state  <= w_state;
      r_resume <= w_resume;
      r_frm    <= w_frm;
      r_s1     <= w_s1;
      r_s2     <= w_s2;
      r_win    <= w_win;
      r_sl     <= w_sl;
      r_br     <= w_br;
      r_run    <= (w_state == PLAY);
      r_led    <= 8'h01 << w_state;
    end
  end

  assign run        = r_run;
  assign ball_reset = r_br;
  assign serve_left = r_sl;
  assign score_1    = r_s1;
  assign score_2    = r_s2;
  assign winner     = r_win;
  assign state      = r_state;
  assign led        = r_led;
endmodule
